// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for pipe_chain_reg
package pipe_pkg;
  localparam int PERF_CNT_W = 32;
  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c += 4'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/pipe_chain_stage.sv
// pipe_chain_stage: one valid+data slot; flush beats hold beats capture
module pipe_chain_stage #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             hold,
  input  logic             flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= RST_VALUE;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_data  <= INIT_VALUE;
    end else if (!hold) begin
      r_valid <= src_valid;
      r_data  <= src_data;
    end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/pipe_chain_reg.sv
// pipe_chain_reg: DEPTH-stage stall/flush register chain with bubble collapse.
// Define PIPE_CHAIN_PERF_EN to build the saturating stall/squash counters.
module pipe_chain_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT_VALUE = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] RST_VALUE = WIDTH'(32'h1_0000)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_stall,
  input  logic [DEPTH-1:0]            flush,
  input  logic                        out_stall,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [clog2p1(DEPTH)-1:0]   occupancy,
  output logic [PERF_CNT_W-1:0]       stall_cycles,
  output logic [PERF_CNT_W-1:0]       squash_count
);
  localparam int OCC_W = clog2p1(DEPTH);
  logic [DEPTH-1:0]            w_valid, w_hold, w_src_valid;
  logic [DEPTH-1:0][WIDTH-1:0] w_data, w_src_data;
  // an empty stage never holds, so entries slide into bubbles under a stall
  always_comb begin
    w_hold = '0;
    w_hold[DEPTH-1] = w_valid[DEPTH-1] & out_stall;
    for (int k = DEPTH - 2; k >= 0; k--) w_hold[k] = w_valid[k] & w_hold[k+1];
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_src_valid[k] = in_valid;
      assign w_src_data[k]  = in_data;
    end else begin : g_body
      assign w_src_valid[k] = w_valid[k-1];
      assign w_src_data[k]  = w_data[k-1];
    end
    pipe_chain_stage #(
      .WIDTH(WIDTH),
      .INIT_VALUE(INIT_VALUE),
      .RST_VALUE(RST_VALUE)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .src_valid(w_src_valid[k]),
      .src_data(w_src_data[k]),
      .hold(w_hold[k]),
      .flush(flush[k]),
      .o_valid(w_valid[k]),
      .o_data(w_data[k])
    );
  end
  assign in_stall  = w_hold[0];
  assign out_valid = w_valid[DEPTH-1];
  assign out_data  = w_data[DEPTH-1];
  assign occupancy = OCC_W'(popcount8(8'(w_valid)));
`ifdef PIPE_CHAIN_PERF_EN
  logic [PERF_CNT_W-1:0] r_stall_cycles, r_squash_count;
  logic [PERF_CNT_W:0]   w_squash_sum;
  // a squash is a flushed stage that would otherwise have held or captured a valid entry
  assign w_squash_sum = {1'b0, r_squash_count} +
    (PERF_CNT_W+1)'(popcount8(8'(flush & (w_hold | (w_src_valid & ~w_hold)))));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_stall_cycles <= '0;
      r_squash_count <= '0;
    end else begin
      if (in_valid && w_hold[0] && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + PERF_CNT_W'(1);
      r_squash_count <= w_squash_sum[PERF_CNT_W] ? '1 : w_squash_sum[PERF_CNT_W-1:0];
    end
  assign stall_cycles = r_stall_cycles;
  assign squash_count = r_squash_count;
`else
  assign stall_cycles = '0;
  assign squash_count = '0;
`endif
endmodule

// File: tb/tb_pipe_chain_reg.sv
// tb_pipe_chain_reg: directed vectors against a per-stage behavioural model of the chain
module tb_pipe_chain_reg;
  localparam int D = 3;
  localparam logic [31:0] RSTV = 32'h0001_0000;
  localparam logic [31:0] INITV = 32'h0;
`ifdef PIPE_CHAIN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_stall = 1'b0;
  logic [31:0] in_data = '0;
  logic [D-1:0] flush = '0;
  logic in_stall, out_valid;
  logic [31:0] out_data, stall_cycles, squash_count;
  logic [1:0] occupancy;
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  pipe_chain_reg #(.WIDTH(32), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_stall(in_stall),
    .flush(flush), .out_stall(out_stall), .out_valid(out_valid), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles), .squash_count(squash_count)
  );
  logic mv [D];
  logic [31:0] md [D];
  logic [31:0] m_stall, m_squash;
  function automatic logic [D-1:0] m_hold();
    logic [D-1:0] h;
    logic nxt;
    h = '0;
    nxt = out_stall;
    for (int k = D - 1; k >= 0; k--) begin
      h[k] = mv[k] & nxt;
      nxt = h[k];
    end
    return h;
  endfunction
  function automatic logic [31:0] m_occ();
    logic [31:0] n;
    n = 0;
    for (int k = 0; k < D; k++) n += 32'(mv[k]);
    return n;
  endfunction
  always @(posedge clk or negedge rst) begin
    logic [D-1:0] h;
    logic sv;
    logic [31:0] sd;
    logic [32:0] sq;
    if (!rst) begin
      for (int k = 0; k < D; k++) begin
        mv[k] <= 1'b0;
        md[k] <= RSTV;
      end
      m_stall <= '0;
      m_squash <= '0;
    end else begin
      h = m_hold();
      sq = {1'b0, m_squash};
      for (int k = 0; k < D; k++) begin
        sv = (k == 0) ? in_valid : mv[(k == 0) ? 0 : k - 1];
        sd = (k == 0) ? in_data : md[(k == 0) ? 0 : k - 1];
        if (flush[k]) begin
          if (h[k] || sv) sq = sq + 33'd1;
          mv[k] <= 1'b0;
          md[k] <= INITV;
        end else if (!h[k]) begin
          mv[k] <= sv;
          md[k] <= sd;
        end
      end
      if (in_valid && h[0] && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 1;
      m_squash <= sq[32] ? 32'hFFFF_FFFF : sq[31:0];
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    logic [D-1:0] h;
    h = m_hold();
    chk("out_valid", 32'(out_valid), 32'(mv[D-1]));
    chk("out_data", out_data, md[D-1]);
    chk("in_stall", 32'(in_stall), 32'(h[0]));
    chk("occupancy", 32'(occupancy), m_occ());
    chk("stall_cycles", stall_cycles, PERF ? m_stall : 32'h0);
    chk("squash_count", squash_count, PERF ? m_squash : 32'h0);
  end
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", out_data, 32'h0001_0000);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_stall", 32'(in_stall), 32'h0);
    step();
    rst = 1'b1;
    in_valid = 1'b1; in_data = 32'hA1; step();
    in_data = 32'hA2; step();
    in_data = 32'hA3; step();
    chk("stream_a1", out_data, 32'hA1);
    chk("stream_v1", 32'(out_valid), 32'h1);
    in_valid = 1'b0; step();
    chk("stream_a2", out_data, 32'hA2);
    step();
    chk("stream_a3", out_data, 32'hA3);
    chk("stream_v3", 32'(out_valid), 32'h1);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_data", out_data, 32'h0001_0000);
    chk("midrst_occ", 32'(occupancy), 32'h0);
    chk("midrst_stall", 32'(in_stall), 32'h0);
    step();
    rst = 1'b1;
    in_valid = 1'b1; in_data = 32'hB0; step();
    in_valid = 1'b0; step();
    in_valid = 1'b1; in_data = 32'hB1; out_stall = 1'b1; step();
    chk("bub_occ2", 32'(occupancy), 32'h2);
    chk("bub_nostall", 32'(in_stall), 32'h0);
    in_valid = 1'b0; step();
    chk("bub_collapse_occ", 32'(occupancy), 32'h2);
    chk("bub_collapse_stall", 32'(in_stall), 32'h0);
    chk("bub_out_b0", out_data, 32'hB0);
    in_valid = 1'b1; in_data = 32'hB2; step();
    chk("bub_full_stall", 32'(in_stall), 32'h1);
    chk("bub_full_occ", 32'(occupancy), 32'h3);
    flush = 3'b010; in_data = 32'hB3; step();
    flush = '0;
    chk("fl_occ", 32'(occupancy), 32'h2);
    chk("fl_out_b0", out_data, 32'hB0);
    chk("fl_out_v", 32'(out_valid), 32'h1);
    chk("fl_stall", 32'(in_stall), 32'h0);
    out_stall = 1'b0; in_valid = 1'b0; step();
    chk("drain_bubble", 32'(out_valid), 32'h0);
    step();
    chk("drain_b2", out_data, 32'hB2);
    chk("drain_b2_v", 32'(out_valid), 32'h1);
    step();
    step();
    in_valid = 1'b1; in_data = 32'hC0; flush = 3'b001; step();
    flush = '0; in_valid = 1'b0;
    chk("cap_flush_occ", 32'(occupancy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("cap_flush_v", 32'(out_valid), 32'h0);
    end
    rst = 1'b0; step(); rst = 1'b1;
    out_stall = 1'b1; in_valid = 1'b1;
    in_data = 32'hE0; step();
    in_data = 32'hE1; step();
    in_data = 32'hE2; step();
    chk("perf_full_stall", 32'(in_stall), 32'h1);
    for (int i = 0; i < 5; i++) step();
    chk("perf_stall5", stall_cycles, PERF ? 32'd5 : 32'd0);
    in_valid = 1'b0; flush = 3'b100; step();
    flush = '0;
    chk("perf_squash1", squash_count, PERF ? 32'd1 : 32'd0);
    chk("perf_stall_kept", stall_cycles, PERF ? 32'd5 : 32'd0);
    chk("perf_fl_out_v", 32'(out_valid), 32'h0);
    chk("perf_fl_occ", 32'(occupancy), 32'h2);
    out_stall = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("final_occ", 32'(occupancy), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pipe_chain_reg.md
Name: pipe_chain_reg

Overview:
- Parametrised successor to the single stall/flush datapath register.
- A chain of DEPTH pipeline stages, each WIDTH bits wide, with a per-stage valid bit.
- Per-stage flush.
- Bubble-collapsing stall propagation: a held stage only stalls its upstream neighbour when the held stage is occupied.
- Sits between pipeline phases (for example, an IF->ID->EX bundle) or serves as an elastic skid/delay line in front of memory.

Parameters:
- WIDTH, 32, payload width per stage.
- DEPTH, 2, number of stages; legal range 1..8.
- INIT_VALUE, {WIDTH{1'b0}}, data loaded into a stage when that stage is flushed.
- RST_VALUE, 32'h1_0000 (zero-extended or truncated to WIDTH), data loaded into every stage on reset.

Ports:
- clk  input  1  clock; rising edge.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  stage-0 capture candidate is valid.
- in_data  input  WIDTH  stage-0 payload.
- in_stall  output  1  upstream must hold in_valid/in_data this cycle; combinational.
- flush  input  DEPTH  flush[k] squashes what stage k captures at this edge.
- out_stall  input  1  downstream cannot accept the stage DEPTH-1 entry.
- out_valid  output  1  valid bit of stage DEPTH-1.
- out_data  output  WIDTH  data of stage DEPTH-1.
- occupancy  output  $clog2(DEPTH+1)  number of set valid bits; combinational popcount.
- stall_cycles  output  32  performance counter (see Optional Feature).
- squash_count  output  32  performance counter (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - all valid bits = 0;
  - all data = RST_VALUE;
  - counters = 0.
  - Reset mid-operation discards all contents immediately; out_valid drops without waiting for a clock edge.
- Hold chain, combinational from registered valid bits; flush does not affect it:
  - hold[DEPTH-1] = valid[DEPTH-1] & out_stall;
  - hold[k] = valid[k] & hold[k+1].
- in_stall = hold[0].
- Per stage k at each rising edge, in priority order:
  1. flush[k]=1: valid[k]<=0, data[k]<=INIT_VALUE. Applies whether or not hold[k] is set, so flush beats stall.
  2. hold[k]=1: stage k keeps its valid and data.
  3. Otherwise, stage k captures from its source. For k=0 the source is in_valid/in_data; for k>0 it is valid[k-1]/data[k-1].
     - Data is captured even when the source valid bit is 0.
- Bubble collapse: an empty stage never holds. An entry therefore advances into a bubble while the downstream stages stay stalled.
- Upstream entries of a flushed-and-held stage remain held for that cycle. This is conservative and intended.
- Latency with no stalls: in_data appears on out_data exactly DEPTH cycles after capture.
- Throughput: 1 entry per cycle.
- No entry is ever duplicated or dropped except by flush.
- A simultaneous out_stall and in_valid on a full chain gives in_stall=1. Upstream holds, and nothing changes.
- DEPTH=1: in_stall = valid[0] & out_stall.

Optional Feature:
- Macro: PIPE_CHAIN_PERF_EN.
- When defined:
  - stall_cycles increments on every edge with in_valid & in_stall.
  - squash_count increments by the number of stages k whose flush[k] is set while their capture source valid is 1 and hold[k]=0, plus stages flushed while holding a valid entry.
  - Both counters are 32-bit, saturating at 32'hFFFF_FFFF, and cleared only by reset.
- When undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Package pipe_pkg holds:
  - the counter width constant PERF_CNT_W=32;
  - a popcount function sized for DEPTH up to 8;
  - the occupancy width function clog2p1(n).
- One natural sub-module: pipe_chain_stage.
  - Contains a single valid+data register with inputs src_valid, src_data, hold, flush.
  - Parameters: WIDTH, INIT_VALUE, RST_VALUE.
  - Instantiated DEPTH times with a generate loop.
- The top level owns the hold chain, occupancy and counters.

Test Plan:
- Reset: WIDTH=32, DEPTH=2, drive rst=0 mid-stream -> out_valid=0, out_data=32'h0001_0000 and occupancy=0 immediately; in_stall=0.
- Streaming: push 0xA1, 0xA2, 0xA3 on consecutive cycles with out_stall=0 -> out_data shows 0xA1, 0xA2, 0xA3 on cycles 2, 3, 4 with out_valid=1; in_stall never asserted.
- Bubble collapse: DEPTH=3, stage 2 = 0xB0 valid, stage 1 empty, stage 0 = 0xB1, out_stall=1 -> next edge: stage 1 = 0xB1 and in_stall=0; after stage 0 refills, in_stall=1 and occupancy=3.
- Flush priority: full chain, out_stall=1, flush=3'b010 -> stage 1 becomes valid=0 with data=INIT_VALUE; stages 0 and 2 unchanged; occupancy drops 3->2.
- Flush on capture: in_valid=1, in_data=0xC0, flush[0]=1, chain empty -> stage 0 stays empty; 0xC0 never reaches out_valid.
- Perf (PIPE_CHAIN_PERF_EN): hold in_stall=1 with in_valid=1 for 5 cycles, then flush a valid stage once -> stall_cycles=5, squash_count=1. Without the macro, both read 0.
